// File: rtl/log_lane_scheduler.sv
// log_lane_scheduler: per-lane pool of moving logs, spawned at frame gaps and retired off the right edge.
// Define LOG_LANE_RANDOM_GAP_EN for LFSR-jittered spawn gaps (GAP_MIN..GAP_MIN+15).
module log_lane_scheduler #(
    parameter int NUM_SLOTS    = 4,
    parameter int X_W          = 11,
    parameter int LOG_WIDTH    = 96,
    parameter int SCREEN_WIDTH = 320,
    parameter int LOG_SPEED    = 4,
    parameter int GAP_MIN      = 32,
    localparam int SW          = NUM_SLOTS > 1 ? $clog2(NUM_SLOTS) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     frame_tick,
    output logic [NUM_SLOTS-1:0]     slot_valid,
    output logic [NUM_SLOTS*X_W-1:0] slot_x,
    output logic                     spawn_pulse,
    output logic [SW-1:0]            spawn_slot,
    output logic                     stall
);
    localparam int GW = $clog2(GAP_MIN + 16) + 1;
    localparam logic signed [X_W-1:0] X_START = X_W'(-LOG_WIDTH);
    localparam logic signed [X_W-1:0] X_END   = X_W'(SCREEN_WIDTH);
    typedef enum logic [1:0] {IDLE, COUNT, PENDING} state_t;
    state_t                 state;
    logic [GW-1:0]          gap_cnt, gap;
    logic [NUM_SLOTS-1:0]   live;
    logic [NUM_SLOTS*X_W-1:0] adv;
    logic [SW-1:0]          free_idx;
    logic                   tick, due, spawn;
    assign tick = enable && frame_tick;
    always_comb begin
        adv  = '0;
        live = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            adv[i*X_W +: X_W] = slot_x[i*X_W +: X_W] + X_W'(LOG_SPEED);
            live[i] = slot_valid[i] && ($signed(adv[i*X_W +: X_W]) < X_END);
        end
    end
    // Slots retired on this tick already count as free, so retire and respawn can coincide.
    always_comb begin
        free_idx = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--)
            if (!live[i]) free_idx = SW'(i);
    end
    assign due   = (state != COUNT) || (gap_cnt == '0);
    assign spawn = due && !(&live);
`ifdef LOG_LANE_RANDOM_GAP_EN
    logic [7:0] lfsr;
    assign gap = GW'(GAP_MIN) + GW'(lfsr[3:0]);
    always_ff @(posedge clk)
        if (reset)
            lfsr <= 8'hA5;
        else if (tick)
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
`else
    assign gap = GW'(GAP_MIN);
`endif
    always_ff @(posedge clk) begin
        if (reset) begin
            slot_valid  <= '0;
            slot_x      <= {NUM_SLOTS{X_START}};
            spawn_pulse <= 1'b0;
            spawn_slot  <= '0;
            stall       <= 1'b0;
            state       <= IDLE;
            gap_cnt     <= '0;
        end else begin
            spawn_pulse <= 1'b0;
            if (tick) begin
                for (int i = 0; i < NUM_SLOTS; i++)
                    if (slot_valid[i]) slot_x[i*X_W +: X_W] <= adv[i*X_W +: X_W];
                slot_valid <= live;
                if (spawn) begin
                    slot_valid[free_idx]             <= 1'b1;
                    slot_x[free_idx*X_W +: X_W]      <= X_START;
                    spawn_pulse                      <= 1'b1;
                    spawn_slot                       <= free_idx;
                    gap_cnt                          <= gap - 1'b1;
                    state                            <= COUNT;
                    stall                            <= 1'b0;
                end else if (due) begin
                    state <= PENDING;
                    stall <= 1'b1;
                end else begin
                    gap_cnt <= gap_cnt - 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_log_lane_scheduler.sv
// tb_log_lane_scheduler: directed and randomized checks of a 4-slot and a 2-slot lane
// against a tick-count reference model.
module tb_log_lane_scheduler;
    logic        clk = 1'b0;
    logic        reset = 1'b1, enable = 1'b0, frame_tick = 1'b0;
    logic [3:0]  v4;
    logic [43:0] x4;
    logic        p4, st4;
    logic [1:0]  s4;
    logic [1:0]  v2;
    logic [21:0] x2;
    logic        p2, st2;
    logic [0:0]  s2;
    int n_checks = 0, n_pass = 0;
    // Model: per lane, slot arrays plus "ticks since last spawn" versus the chosen gap.
    bit       mv[2][4];
    int       mx[2][4];
    int       since[2], gapm[2], ms[2];
    bit       first[2], mp[2], mst[2];
    bit [7:0] ml[2];

    always #5 clk = ~clk;

    log_lane_scheduler dut4 (.clk(clk), .reset(reset), .enable(enable), .frame_tick(frame_tick),
        .slot_valid(v4), .slot_x(x4), .spawn_pulse(p4), .spawn_slot(s4), .stall(st4));
    log_lane_scheduler #(.NUM_SLOTS(2)) dut2 (.clk(clk), .reset(reset), .enable(enable),
        .frame_tick(frame_tick), .slot_valid(v2), .slot_x(x2), .spawn_pulse(p2),
        .spawn_slot(s2), .stall(st2));

    task automatic model_edge(input bit r, input bit en, input bit ft);
        for (int d = 0; d < 2; d++) begin
            int n = (d == 0) ? 4 : 2;
            int fi = -1;
            bit due;
            if (r) begin
                for (int i = 0; i < 4; i++) begin mv[d][i] = 0; mx[d][i] = -96; end
                since[d] = 0; gapm[d] = 32; ms[d] = 0; first[d] = 1; mp[d] = 0; mst[d] = 0;
                ml[d] = 8'hA5;
                continue;
            end
            mp[d] = 0;
            if (en && ft) begin
                for (int i = 0; i < n; i++)
                    if (mv[d][i]) begin
                        mx[d][i] += 4;
                        if (mx[d][i] >= 320) mv[d][i] = 0;
                    end
                if (!first[d]) since[d]++;
                due = first[d] || since[d] >= gapm[d];
                for (int i = n - 1; i >= 0; i--) if (!mv[d][i]) fi = i;
                if (due && fi >= 0) begin
                    mv[d][fi] = 1; mx[d][fi] = -96; mp[d] = 1; ms[d] = fi;
                    first[d] = 0; since[d] = 0; mst[d] = 0;
`ifdef LOG_LANE_RANDOM_GAP_EN
                    gapm[d] = 32 + int'(ml[d][3:0]);
`else
                    gapm[d] = 32;
`endif
                end else mst[d] = due;
                ml[d] = {ml[d][6:0], ml[d][7] ^ ml[d][5] ^ ml[d][4] ^ ml[d][3]};
            end
        end
    endtask

    task automatic step(input bit r, input bit en, input bit ft);
        @(negedge clk);
        reset = r; enable = en; frame_tick = ft;
        @(posedge clk);
        model_edge(r, en, ft);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) step(1, 1'($urandom), 1'($urandom));
        n_checks++; if (v4 !== 4'b0) $display("FAIL reset_valid4 got %b want 0000", v4); else n_pass++;
        n_checks++; if (v2 !== 2'b0) $display("FAIL reset_valid2 got %b want 00", v2); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            int xi = $signed(x4[i*11 +: 11]);
            n_checks++; if (xi != -96) $display("FAIL reset_x%0d got %0d want -96", i, xi); else n_pass++;
        end
        n_checks++; if (st4 !== 1'b0) $display("FAIL reset_stall got %b want 0", st4); else n_pass++;
        n_checks++; if (p4 !== 1'b0) $display("FAIL reset_pulse got %b want 0", p4); else n_pass++;
        n_checks++; if (s4 !== 2'd0) $display("FAIL reset_slot got %0d want 0", s4); else n_pass++;
    endtask

    task automatic test_first_spawn();
        int xi;
        step(1, 0, 0);
        step(0, 1, 1);
        xi = $signed(x4[10:0]);
        n_checks++; if (p4 !== 1'b1) $display("FAIL first_pulse got %b want 1", p4); else n_pass++;
        n_checks++; if (s4 !== 2'd0) $display("FAIL first_slot got %0d want 0", s4); else n_pass++;
        n_checks++; if (xi != -96) $display("FAIL first_x got %0d want -96", xi); else n_pass++;
        n_checks++; if (v4 !== 4'b0001) $display("FAIL first_valid got %b want 0001", v4); else n_pass++;
        step(0, 1, 0);
        n_checks++; if (p4 !== 1'b0) $display("FAIL pulse_drop got %b want 0", p4); else n_pass++;
        for (int i = 0; i < 10; i++) step(0, 1, 1);
        xi = $signed(x4[10:0]);
        n_checks++; if (xi != -56) $display("FAIL motion_x got %0d want -56", xi); else n_pass++;
        for (int i = 0; i < 5; i++) begin step(0, 0, 1); step(0, 0, 0); end
        xi = $signed(x4[10:0]);
        n_checks++; if (xi != -56) $display("FAIL freeze_x got %0d want -56", xi); else n_pass++;
        n_checks++; if (v4 !== 4'b0001) $display("FAIL freeze_valid got %b want 0001", v4); else n_pass++;
    endtask

    task automatic test_schedule();
        step(1, 0, 0);
        for (int k = 0; k <= 140; k++) begin
            step(0, 1, 1);
`ifndef LOG_LANE_RANDOM_GAP_EN
            if (k % 32 == 0 && k <= 96) begin
                n_checks++;
                if (p4 !== 1'b1 || s4 !== 2'(k / 32))
                    $display("FAIL sched_spawn_t%0d got p=%b s=%0d want p=1 s=%0d", k, p4, s4, k / 32);
                else n_pass++;
            end
            if (k == 104) begin
                n_checks++; if (v4[0] !== 1'b0) $display("FAIL sched_retire got %b want 0", v4[0]); else n_pass++;
            end
            if (k == 128) begin
                n_checks++;
                if (p4 !== 1'b1 || s4 !== 2'd0) $display("FAIL sched_reuse got p=%b s=%0d want p=1 s=0", p4, s4);
                else n_pass++;
            end
            if (k == 64) begin
                n_checks++; if (st2 !== 1'b1) $display("FAIL exhaust_stall got %b want 1", st2); else n_pass++;
            end
            if (k == 104) begin
                int xi = $signed(x2[10:0]);
                n_checks++;
                if (p2 !== 1'b1 || s2 !== 1'b0 || xi != -96 || st2 !== 1'b0)
                    $display("FAIL exhaust_respawn0 got p=%b s=%0d x=%0d st=%b want p=1 s=0 x=-96 st=0", p2, s2, xi, st2);
                else n_pass++;
            end
            if (k == 136) begin
                n_checks++;
                if (p2 !== 1'b1 || s2 !== 1'b1) $display("FAIL exhaust_respawn1 got p=%b s=%0d want p=1 s=1", p2, s2);
                else n_pass++;
            end
`endif
        end
    endtask

    task automatic test_random();
        int ticks = 0, last = -1, spawns = 0;
        step(1, 0, 0);
        for (int c = 0; c < 4000; c++) begin
            bit en = ($urandom_range(3) != 0);
            bit ft = ($urandom_range(2) == 0);
            logic [3:0] e4;
            logic [1:0] e2;
            step(0, en, ft);
            if (en && ft) ticks++;
            for (int i = 0; i < 4; i++) e4[i] = mv[0][i];
            for (int i = 0; i < 2; i++) e2[i] = mv[1][i];
            n_checks++; if (v4 !== e4) $display("FAIL rnd_valid4 c=%0d got %b want %b", c, v4, e4); else n_pass++;
            n_checks++; if (v2 !== e2) $display("FAIL rnd_valid2 c=%0d got %b want %b", c, v2, e2); else n_pass++;
            for (int i = 0; i < 4; i++)
                if (mv[0][i]) begin
                    int xi = $signed(x4[i*11 +: 11]);
                    n_checks++; if (xi != mx[0][i]) $display("FAIL rnd_x4_%0d got %0d want %0d", i, xi, mx[0][i]); else n_pass++;
                end
            for (int i = 0; i < 2; i++)
                if (mv[1][i]) begin
                    int xi = $signed(x2[i*11 +: 11]);
                    n_checks++; if (xi != mx[1][i]) $display("FAIL rnd_x2_%0d got %0d want %0d", i, xi, mx[1][i]); else n_pass++;
                end
            n_checks++;
            if (p4 !== mp[0] || int'(s4) != ms[0] || st4 !== mst[0])
                $display("FAIL rnd_ctl4 c=%0d got p=%b s=%0d st=%b want p=%b s=%0d st=%b", c, p4, s4, st4, mp[0], ms[0], mst[0]);
            else n_pass++;
            n_checks++;
            if (p2 !== mp[1] || int'(s2) != ms[1] || st2 !== mst[1])
                $display("FAIL rnd_ctl2 c=%0d got p=%b s=%0d st=%b want p=%b s=%0d st=%b", c, p2, s2, st2, mp[1], ms[1], mst[1]);
            else n_pass++;
            if (p4 === 1'b1) begin
                if (last >= 0) begin
`ifdef LOG_LANE_RANDOM_GAP_EN
                    int hi = 47;
`else
                    int hi = 32;
`endif
                    n_checks++;
                    if (ticks - last < 32 || ticks - last > hi)
                        $display("FAIL rnd_interval got %0d want 32..%0d", ticks - last, hi);
                    else n_pass++;
                end
                last = ticks;
                spawns++;
            end
        end
        n_checks++; if (spawns < 20) $display("FAIL rnd_spawn_count got %0d want >=20", spawns); else n_pass++;
    endtask

    task automatic test_reset_mid();
        step(1, 0, 0);
        for (int k = 0; k <= 50; k++) step(0, 1, 1);
        n_checks++; if (v4 !== 4'b0011) $display("FAIL mid_live got %b want 0011", v4); else n_pass++;
        step(1, 1, 1);
        n_checks++; if (v4 !== 4'b0 || v2 !== 2'b0) $display("FAIL mid_valid got %b/%b want 0/0", v4, v2); else n_pass++;
        n_checks++;
        if (p4 !== 1'b0 || s4 !== 2'd0 || st4 !== 1'b0) $display("FAIL mid_ctl got p=%b s=%0d st=%b want 0 0 0", p4, s4, st4);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            int xi = $signed(x4[i*11 +: 11]);
            n_checks++; if (xi != -96) $display("FAIL mid_x%0d got %0d want -96", i, xi); else n_pass++;
        end
        step(0, 1, 1);
        n_checks++;
        if (p4 !== 1'b1 || s4 !== 2'd0 || v4 !== 4'b0001)
            $display("FAIL mid_respawn got p=%b s=%0d v=%b want p=1 s=0 v=0001", p4, s4, v4);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_first_spawn();
        test_schedule();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/log_lane_scheduler.md
Name: log_lane_scheduler

Overview:
Per-lane controller for the river's moving logs. It owns a fixed pool of log slots and advances every live log once per video frame. It spawns new logs off the left edge at scheduled frame gaps and retires logs once they pass the right edge. Its outputs feed the log renderer and frog-on-log collision logic. One instance per river lane.

Parameters:
NUM_SLOTS, 4, number of log slots in the lane pool
X_W, 11, width of signed two's-complement x position
LOG_WIDTH, 96, log length in pixels (3 blocks of 32)
SCREEN_WIDTH, 320, visible width; x >= this means off-screen
LOG_SPEED, 4, pixels advanced per frame tick
GAP_MIN, 32, minimum frame ticks between spawns (>=1; GAP_MIN*LOG_SPEED >= LOG_WIDTH is the integrator's responsibility)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
enable  in  1  lane run; low freezes all state
frame_tick  in  1  one-cycle pulse per frame (vsync-derived)
slot_valid  out  NUM_SLOTS  slot i holds a live log
slot_x  out  NUM_SLOTS*X_W  packed signed left-edge x; slot i at [i*X_W +: X_W]
spawn_pulse  out  1  one cycle high on the clock a log is spawned
spawn_slot  out  clog2(NUM_SLOTS)  index written by the last spawn
stall  out  1  spawn due but no free slot (PENDING state)

Behaviour:
- Reset values: slot_valid=0, every slot_x=-LOG_WIDTH, spawn_pulse=0, spawn_slot=0, stall=0, state=IDLE, gap_cnt=0, LFSR=8'hA5.
- All outputs are registered. State updates only on clocks where enable && frame_tick ("a tick"). All other cycles hold state, and spawn_pulse returns to 0.
- Movement on a tick: for each valid slot, x_next = x + LOG_SPEED in signed X_W arithmetic.
- Retirement: if x_next >= SCREEN_WIDTH (signed compare), the slot is cleared in the same tick. slot_x takes x_next, which is don't-care once the slot is invalid.
- Free-slot vector: the post-retirement valid vector. A slot freed on tick T is spawnable on tick T.
- Spawn: writes the lowest-index free slot with valid=1 and x=-LOG_WIDTH. The newly spawned log is not advanced on its spawn tick. Spawn also sets spawn_pulse=1 and spawn_slot=index, then loads gap_cnt = gap-1.
- gap = GAP_MIN (see Optional Feature).
- FSM states:
  - IDLE: on the first tick, spawn → COUNT.
  - COUNT: on a tick with gap_cnt != 0, decrement. On a tick with gap_cnt == 0: if a free slot exists, spawn (stay COUNT); else → PENDING.
  - PENDING: stall=1. On each tick, spawn when a free slot exists, then stall=0 → COUNT. The gap restarts from the actual spawn tick.
- Log lifetime: 104 ticks from x=-96 to retirement at 320 with default parameters.
- enable low in any state freezes positions, gap_cnt, LFSR and FSM. frame_tick is ignored.
- reset mid-run returns every register to its reset value on the next clock, regardless of enable or frame_tick.

Optional Feature:
LOG_LANE_RANDOM_GAP_EN.
- Defined: an 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1, seed 8'hA5) shifts once per tick. Spawn uses gap = GAP_MIN + LFSR[3:0], range GAP_MIN..GAP_MIN+15, sampled on the spawn tick.
- Undefined: no LFSR, gap = GAP_MIN constant, fully deterministic.

Test Plan:
- Reset: hold reset 3 clocks → slot_valid=0, all slot_x=-96, stall=0, spawn_pulse=0.
- First spawn and motion: enable=1, tick 0 → spawn_pulse one cycle, spawn_slot=0, slot_x[0]=-96. After 10 more ticks → slot_x[0]=-56. Holding enable=0 across 5 frame_ticks → slot_x[0] stays -56.
- Gap schedule (macro undefined): spawns on ticks 0/32/64/96 into slots 0/1/2/3. Slot 0 retires at tick 104 (valid drops). Tick 128 spawns into slot 0.
- Exhaustion and simultaneous retire/spawn, NUM_SLOTS=2:
  - Spawns on ticks 0 and 32. Tick 64 → stall=1.
  - Tick 104: slot 0 retires and respawns in the same tick (spawn_slot=0, x=-96), stall=0.
  - Tick 136: slot 1 retires and respawns.
- Random gap (macro defined): over 20 spawns, every inter-spawn interval lies in 32..47. The sequence matches the LFSR reference model seeded with A5.
- Reset mid-run: assert reset at tick 50 with 2 live logs → all outputs return to reset values. The next tick after release spawns slot 0.
